bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 tb/tb_bin2bcd_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/done handshake.
// Optional leading-zero blank mask output enabled by defining BIN2BCD_BLANK_EN.

module bin2bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iStart,
  input  logic [BIN_W-1:0]      iBin,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [4*DIGITS-1:0]   oBCD
`ifdef BIN2BCD_BLANK_EN
  ,output logic [DIGITS-1:0]    oBlank
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [BIN_W-1:0]      bin_sh;
  logic [4*DIGITS-1:0]   bcd_work;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [CNT_W-1:0]      cnt;

  // All digits are corrected in parallel on the pre-shift value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2bcd_digit u_dig (
      .d(bcd_work[4*g +: 4]),
      .q(bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign oBusy = (state != S_IDLE);

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              above_zero;

  // Digit 0 is never blanked so zero still shows a single "0".
  always_comb begin
    blank_nxt  = '0;
    above_zero = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      above_zero   = above_zero & (bcd_work[4*i +: 4] == 4'd0);
      blank_nxt[i] = above_zero;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST)                oBlank <= '0;
    else if (state == S_DONE) oBlank <= blank_nxt;
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bin_sh   <= '0;
      bcd_work <= '0;
      cnt      <= '0;
      oBCD     <= '0;
      oDone    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        S_IDLE: if (iStart) begin
          bin_sh   <= iBin;
          bcd_work <= '0;
          cnt      <= CNT_W'(BIN_W);
        end
        S_SHIFT: begin
          // Top bit of the highest digit falls off: result is mod 10^DIGITS.
          bcd_work <= (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_sh[BIN_W-1]};
          bin_sh   <= bin_sh << 1;
          cnt      <= cnt - 1'b1;
        end
        S_DONE: begin
          oBCD  <= bcd_work;
          oDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 32-bit/10-digit unit and a 17-bit/4-digit truncating unit.
module tb_bin2bcd_seq;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] bin_a = '0;
  logic [16:0] bin_b = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [39:0] bcd_a;
  logic [15:0] bcd_b;
  logic [9:0]  blank_a;
  logic [3:0]  blank_b;

  int nvec = 0;
  int nerr = 0;

  always #5 iCLK = ~iCLK;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10), .CNT_W(6)) u_dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(start_a), .iBin(bin_a),
    .oBusy(busy_a), .oDone(done_a), .oBCD(bcd_a)
`ifdef BIN2BCD_BLANK_EN
    ,.oBlank(blank_a)
`endif
  );

  bin2bcd_seq #(.BIN_W(17), .DIGITS(4), .CNT_W(5)) u_trunc (
    .iCLK(iCLK), .iRST(iRST), .iStart(start_b), .iBin(bin_b),
    .oBusy(busy_b), .oDone(done_b), .oBCD(bcd_b)
`ifdef BIN2BCD_BLANK_EN
    ,.oBlank(blank_b)
`endif
  );

`ifndef BIN2BCD_BLANK_EN
  assign blank_a = '0;
  assign blank_b = '0;
`endif

  // Drives one conversion and waits (bounded) for oDone; returns what was seen.
  task automatic conv(input bit sel, input logic [31:0] v, output logic [39:0] bcd,
                      output logic [9:0] blank, output int cyc, output int busy, output bit to);
    if (sel) begin bin_b = v[16:0]; start_b = 1'b1; end
    else     begin bin_a = v;       start_a = 1'b1; end
    @(posedge iCLK); #1;
    start_a = 1'b0; start_b = 1'b0;
    bin_a = 32'hDEAD_BEEF; bin_b = 17'h1ABCD;
    cyc = 0; busy = 0; to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge iCLK);
      if (sel ? busy_b : busy_a) busy++;
      if (sel ? done_b : done_a) begin to = 1'b0; break; end
      @(posedge iCLK); cyc++;
    end
    bcd   = sel ? {24'h0, bcd_b} : bcd_a;
    blank = sel ? {6'h0, blank_b} : blank_a;
  endtask

  task automatic test_reset;
    iRST = 1'b1; start_a = 1'b1; bin_a = 32'd77;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    nvec++; if (done_a !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done_a); end
    nvec++; if (bcd_a !== 40'h0) begin nerr++; $display("FAIL reset_bcd: got %h want 0", bcd_a); end
    nvec++; if (blank_a !== 10'h0) begin nerr++; $display("FAIL reset_blank: got %b want 0", blank_a); end
    iRST = 1'b0; start_a = 1'b0;
    @(negedge iCLK);
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL reset_start_dropped: got busy %b want 0", busy_a); end
  endtask

  task automatic test_zero;
    logic [39:0] bcd; logic [9:0] blank; int cyc, busy; bit to;
    conv(1'b0, 32'd0, bcd, blank, cyc, busy, to);
    nvec++; if (to) begin nerr++; $display("FAIL zero_timeout: got no oDone want oDone"); end
    nvec++; if (bcd !== 40'h0) begin nerr++; $display("FAIL zero_bcd: got %h want 0", bcd); end
    nvec++; if (cyc !== 33) begin nerr++; $display("FAIL zero_latency: got %0d want 33", cyc); end
`ifdef BIN2BCD_BLANK_EN
    nvec++; if (blank !== 10'b11_1111_1110) begin nerr++; $display("FAIL zero_blank: got %b want 1111111110", blank); end
`endif
  endtask

  task automatic test_1234;
    logic [39:0] bcd; logic [9:0] blank; int cyc, busy; bit to;
    conv(1'b0, 32'd1234, bcd, blank, cyc, busy, to);
    nvec++; if (to) begin nerr++; $display("FAIL d1234_timeout: got no oDone want oDone"); end
    nvec++; if (bcd !== 40'h00_0000_1234) begin nerr++; $display("FAIL d1234_bcd: got %h want 0000001234", bcd); end
    nvec++; if (busy !== 33) begin nerr++; $display("FAIL d1234_busy_len: got %0d want 33", busy); end
`ifdef BIN2BCD_BLANK_EN
    nvec++; if (blank !== 10'b11_1111_0000) begin nerr++; $display("FAIL d1234_blank: got %b want 1111110000", blank); end
`endif
    @(negedge iCLK);
    nvec++; if (done_a !== 1'b0) begin nerr++; $display("FAIL d1234_done_pulse: got %b want 0", done_a); end
    nvec++; if (bcd_a !== 40'h1234) begin nerr++; $display("FAIL d1234_hold: got %h want 1234", bcd_a); end
  endtask

  task automatic test_max;
    logic [39:0] bcd; logic [9:0] blank; int cyc, busy; bit to;
    conv(1'b0, 32'hFFFF_FFFF, bcd, blank, cyc, busy, to);
    nvec++; if (to) begin nerr++; $display("FAIL max_timeout: got no oDone want oDone"); end
    nvec++; if (bcd !== 40'h42_9496_7295) begin nerr++; $display("FAIL max_bcd: got %h want 4294967295", bcd); end
`ifdef BIN2BCD_BLANK_EN
    nvec++; if (blank !== 10'h0) begin nerr++; $display("FAIL max_blank: got %b want 0", blank); end
`endif
  endtask

  task automatic test_back_to_back;
    bit seen;
    bin_a = 32'd5678; start_a = 1'b1;
    @(posedge iCLK); #1 start_a = 1'b0;
    repeat (9) @(posedge iCLK);
    #1; start_a = 1'b1; bin_a = 32'd99;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge iCLK);
      if (done_a) seen = 1'b1;
    end
    nvec++; if (!seen) begin nerr++; $display("FAIL b2b_first_timeout: got no oDone want oDone"); end
    nvec++; if (bcd_a !== 40'h5678) begin nerr++; $display("FAIL b2b_ignore: got %h want 5678", bcd_a); end
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL b2b_idle_after_done: got busy %b want 0", busy_a); end
    @(negedge iCLK);
    nvec++; if (busy_a !== 1'b1) begin nerr++; $display("FAIL b2b_restart: got busy %b want 1", busy_a); end
    start_a = 1'b0;
    repeat (10) @(negedge iCLK);
    nvec++; if (bcd_a !== 40'h5678) begin nerr++; $display("FAIL b2b_hold_mid: got %h want 5678", bcd_a); end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge iCLK);
      if (done_a) seen = 1'b1;
    end
    nvec++; if (!seen) begin nerr++; $display("FAIL b2b_second_timeout: got no oDone want oDone"); end
    nvec++; if (bcd_a !== 40'h99) begin nerr++; $display("FAIL b2b_second: got %h want 99", bcd_a); end
  endtask

  task automatic test_abort;
    logic [39:0] bcd; logic [9:0] blank; int cyc, busy, ndone; bit to;
    @(posedge iCLK); #1;
    bin_a = 32'd987654; start_a = 1'b1;
    @(posedge iCLK); #1 start_a = 1'b0;
    repeat (14) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(posedge iCLK); #1 iRST = 1'b0;
    @(negedge iCLK);
    nvec++; if (busy_a !== 1'b0) begin nerr++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    nvec++; if (bcd_a !== 40'h0) begin nerr++; $display("FAIL abort_bcd: got %h want 0", bcd_a); end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_a) ndone++;
      @(negedge iCLK);
    end
    nvec++; if (ndone !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    conv(1'b0, 32'd42, bcd, blank, cyc, busy, to);
    nvec++; if (to) begin nerr++; $display("FAIL abort_restart_timeout: got no oDone want oDone"); end
    nvec++; if (bcd !== 40'h42) begin nerr++; $display("FAIL abort_restart: got %h want 42", bcd); end
  endtask

  task automatic test_truncate;
    logic [39:0] bcd; logic [9:0] blank; int cyc, busy; bit to;
    conv(1'b1, 32'd12345, bcd, blank, cyc, busy, to);
    nvec++; if (to) begin nerr++; $display("FAIL trunc_timeout: got no oDone want oDone"); end
    nvec++; if (bcd[15:0] !== 16'h2345) begin nerr++; $display("FAIL trunc_12345: got %h want 2345", bcd[15:0]); end
    nvec++; if (cyc !== 18) begin nerr++; $display("FAIL trunc_latency: got %0d want 18", cyc); end
    conv(1'b1, 32'd131071, bcd, blank, cyc, busy, to);
    nvec++; if (bcd[15:0] !== 16'h1071) begin nerr++; $display("FAIL trunc_131071: got %h want 1071", bcd[15:0]); end
`ifdef BIN2BCD_BLANK_EN
    nvec++; if (blank[3:0] !== 4'b0000) begin nerr++; $display("FAIL trunc_blank: got %b want 0000", blank[3:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_max();
    test_back_to_back();
    test_abort();
    test_truncate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
